// File: rtl/nios2os_oci_pkg.sv
`default_nettype none
// ============================================================================
// nios2os_oci_pkg : shared types and defaults for the OCI DCT trace monitor
// Revision 1.0
// ============================================================================
package nios2os_oci_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_DCT_W  = 30;
    localparam int DEF_SLOT_W = 2;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_OVF_W  = 16;

    function automatic int max_slots(input int dct_w, input int slot_w);
        return dct_w / slot_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios2os_oci_sync_fifo.sv
`default_nettype none
// ============================================================================
// nios2os_oci_sync_fifo : DEPTH x WIDTH FIFO, registered head, push/pop/flush
// Revision 1.0
// ============================================================================
module nios2os_oci_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_next;
    logic [PW-1:0]    rd_next;
    logic [PW-1:0]    fill_next;
    logic [PW-1:0]    fill_after_pop;
    logic [WIDTH-1:0] head_next;
    logic             do_pop;
    logic             do_push;

    assign fill_level = wr_ptr - rd_ptr;
    assign do_pop     = pop && out_valid;
    assign do_push    = push && ((fill_level != PW'(DEPTH)) || do_pop);

    // The head register is reloaded every edge with whatever entry will sit at
    // the read pointer afterwards; an entry written into an emptying FIFO
    // bypasses the array so the push-to-output latency stays at one cycle.
    always_comb begin
        rd_next        = rd_ptr + PW'(do_pop);
        wr_next        = wr_ptr + PW'(do_push);
        fill_next      = wr_next - rd_next;
        fill_after_pop = fill_level - PW'(do_pop);
        head_next      = (fill_after_pop == '0) ? din : mem[rd_next[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            out_valid <= (fill_next != '0);
            if (fill_next != '0) begin
                out_data <= head_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios2os_nios2_oci_dct_monitor.sv
`default_nettype none
// ============================================================================
// nios2os_nios2_oci_dct_monitor : DCT snapshot capture FIFO with end-of-test
// drain sequencing, overflow and malformed-count tracking.   Revision 1.0
// ============================================================================
module nios2os_nios2_oci_dct_monitor
    import nios2os_oci_pkg::*;
#(
    parameter int DCT_W  = DEF_DCT_W,
    parameter int SLOT_W = DEF_SLOT_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int OVF_W  = DEF_OVF_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DCT_W-1:0]             dct_buffer,
    input  logic [CNT_W-1:0]             dct_count,
    input  logic                         dct_valid,
    input  logic                         test_ending,
    input  logic                         test_has_ended,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DCT_W+CNT_W-1:0]       out_data,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic [OVF_W-1:0]             drop_cnt,
    output logic                         count_err,
    output logic                         done
);

    localparam int              MAX_SLOTS = max_slots(DCT_W, SLOT_W);
    localparam int              FILL_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SLOTS);

    state_t           state;
    logic [DCT_W-1:0] masked;
    logic             candidate;
    logic             count_bad;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    for (genvar i = 0; i < MAX_SLOTS; i++) begin : g_slot
        localparam logic [CNT_W-1:0] IDX = CNT_W'(i);
        assign masked[i*SLOT_W +: SLOT_W] =
            (IDX < dct_count) ? dct_buffer[i*SLOT_W +: SLOT_W] : '0;
    end

    // test_ending closes the push window in the same cycle it is raised.
    assign candidate = dct_valid && (state == ST_RUN) && !test_ending &&
                       !test_has_ended && (dct_count != '0);
    assign count_bad = dct_count > MAX_CNT;
    assign fifo_full = (fill_level == FILL_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = candidate && !count_bad && (!fifo_full || pop);
    assign drop      = candidate && !count_bad && fifo_full && !pop;

    nios2os_oci_sync_fifo #(
        .WIDTH (DCT_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .din        ({dct_count, masked}),
        .pop        (pop),
        .flush      (test_has_ended),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fill_level (fill_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            done      <= 1'b0;
            drop_cnt  <= '0;
            count_err <= 1'b0;
        end else begin
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (candidate && count_bad) begin
                count_err <= 1'b1;
            end
            if (test_has_ended) begin
                state <= ST_DONE;
                done  <= 1'b1;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (test_ending) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if ((fill_level == '0) && !pop) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state <= ST_RUN;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
